// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file with post-reset init sweep and link-register write.
// Optional write-first read bypass when RF_BYPASS_EN is defined; read-first otherwise.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 3,
  parameter int LINK_REG = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*OUT_W-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [OUT_W-1:0]        wr_data,
  input  logic                    link_en,
  output logic [OUT_W-1:0]        link_q,
  output logic                    busy
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [AW-1:0]     eff_addr;
  logic              run_wr;
  logic [DATA_W-1:0] rd_val [NUM_RD];
  logic [DATA_W-1:0] link_val;

  assign busy     = (state == INIT);
  assign eff_addr = link_en ? LINK_A : wr_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sweep writes reg[cnt]=cnt (reg 0 naturally gets 0); in RUN the port write is steered here.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_waddr = cnt;
    mem_wdata = DATA_W'(cnt);
    run_wr    = 1'b0;
    case (state)
      INIT: begin
        mem_we  = !rst;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN: begin
        run_wr = !rst && wr_en && (eff_addr != '0);
        if (run_wr) begin
          mem_we    = 1'b1;
          mem_waddr = eff_addr;
          mem_wdata = wr_data[DATA_W-1:0];
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = '0;
      if (rd_addr[p*AW +: AW] != '0) begin
        rd_val[p] = mem[rd_addr[p*AW +: AW]];
`ifdef RF_BYPASS_EN
        if (run_wr && (rd_addr[p*AW +: AW] == eff_addr)) rd_val[p] = wr_data[DATA_W-1:0];
`endif
      end
    end
    link_val = (LINK_A == '0) ? '0 : mem[LINK_A];
`ifdef RF_BYPASS_EN
    if (run_wr && (eff_addr == LINK_A)) link_val = wr_data[DATA_W-1:0];
`endif
  end

  // Outputs stay at zero through reset and the whole sweep, including the edge that enters RUN.
  always_ff @(posedge clk) begin
    if (rst || state == INIT) begin
      rd_data <= '0;
      link_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) rd_data[p*OUT_W +: OUT_W] <= OUT_W'(rd_val[p]);
      link_q <= OUT_W'(link_val);
    end
  end

  if (OUT_W > DATA_W) begin : g_hi
    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_data[OUT_W-1:DATA_W];
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport against an array model.
// Expected same-cycle read/write behaviour follows RF_BYPASS_EN when defined.
module tb_regfile_multiport;

  logic         clk = 1'b0;
  logic         rst;
  logic [14:0]  rd_addr;
  logic [191:0] rd_data;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         link_en;
  logic [63:0]  link_q;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];
  logic [63:0] exp_rd [3];
  logic [63:0] exp_link;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_multiport dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_q(link_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] expect_read(input logic [4:0] a, input logic act,
                                              input logic [4:0] eff, input logic [63:0] wd);
    if (a == 5'd0) return 64'd0;
    if (BYPASS && act && a == eff) return {32'd0, wd[31:0]};
    return {32'd0, model[a]};
  endfunction

  // One RUN cycle: drive, predict outputs from the model, clock, then commit the write to the model.
  task automatic run_cycle(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                           input logic we, input logic [4:0] wa, input logic [63:0] wd,
                           input logic le);
    logic [4:0] addrs [3];
    logic [4:0] eff;
    logic       act;
    addrs   = '{a0, a1, a2};
    rd_addr = {a2, a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    link_en = le;
    eff = le ? 5'd31 : wa;
    act = we && eff != 5'd0;
    for (int p = 0; p < 3; p++) exp_rd[p] = expect_read(addrs[p], act, eff, wd);
    exp_link = expect_read(5'd31, act, eff, wd);
    tick();
    if (act) model[eff] = wd[31:0];
    wr_en   = 1'b0;
    link_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; wr_en = 1'b0; link_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick();
    checks++;
    if (busy !== 1'b1 || rd_data !== 192'd0 || link_q !== 64'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b rd_data=%h link_q=%h required busy=1 rd_data=0 link_q=0",
               busy, rd_data, link_q);
    end
    tick();
    rst = 1'b0;
    rd_addr = {5'd0, 5'd17, 5'd5};
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    for (int i = 0; i < 32; i++) model[i] = i;
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL sweep_length busy cycles=%0d required=32", n);
    end
    checks++;
    if (rd_data !== 192'd0 || link_q !== 64'd0) begin
      errors++;
      $display("FAIL sweep_exit_hold rd_data=%h link_q=%h required 0", rd_data, link_q);
    end
    run_cycle(5'd5, 5'd17, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++;
    if (rd_data[63:0] !== 64'h5 || rd_data[127:64] !== 64'h11 || rd_data[191:128] !== 64'h0) begin
      errors++;
      $display("FAIL init_values got=%h required=%h", rd_data, {64'h0, 64'h11, 64'h5});
    end
    checks++;
    if (link_q !== 64'h1F) begin
      errors++;
      $display("FAIL init_link got=%h required=%h", link_q, 64'h1F);
    end
  endtask

  task automatic test_write();
    run_cycle(5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
    run_cycle(5'd7, 5'd7, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rd_data[p*64 +: 64] !== 64'h0000_0000_DEAD_BEEF) begin
        errors++;
        $display("FAIL write_zext port=%0d got=%h required=%h", p, rd_data[p*64 +: 64],
                 64'h0000_0000_DEAD_BEEF);
      end
    end
  endtask

  task automatic test_link();
    run_cycle(5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 64'h1234, 1'b1);
    run_cycle(5'd31, 5'd4, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++;
    if (rd_data[63:0] !== 64'h1234 || link_q !== 64'h1234) begin
      errors++;
      $display("FAIL link_write reg31=%h link_q=%h required=%h", rd_data[63:0], link_q, 64'h1234);
    end
    checks++;
    if (rd_data[127:64] !== 64'h4) begin
      errors++;
      $display("FAIL link_ignores_addr reg4=%h required=%h", rd_data[127:64], 64'h4);
    end
  endtask

  task automatic test_zero_reg();
    run_cycle(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 64'hABCD, 1'b0);
    run_cycle(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++;
    if (rd_data !== 192'd0) begin
      errors++;
      $display("FAIL zero_reg got=%h required=0", rd_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] first;
    first = BYPASS ? 64'h99 : 64'h9;
    run_cycle(5'd0, 5'd9, 5'd0, 1'b1, 5'd9, 64'h99, 1'b0);
    checks++;
    if (rd_data[127:64] !== first) begin
      errors++;
      $display("FAIL same_cycle_rw got=%h required=%h", rd_data[127:64], first);
    end
    run_cycle(5'd0, 5'd9, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++;
    if (rd_data[127:64] !== 64'h99) begin
      errors++;
      $display("FAIL after_same_cycle got=%h required=%h", rd_data[127:64], 64'h99);
    end
  endtask

  task automatic test_random();
    logic [4:0] a [3];
    logic [4:0] wa;
    logic       we, le;
    int         bad;
    for (int i = 0; i < 300; i++) begin
      wa = 5'($urandom_range(0, 31));
      we = ($urandom_range(0, 3) != 0);
      le = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < 3; p++)
        a[p] = ($urandom_range(0, 3) == 0) ? (le ? 5'd31 : wa) : 5'($urandom_range(0, 31));
      run_cycle(a[0], a[1], a[2], we, wa, {$urandom, $urandom}, le);
      bad = 0;
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (rd_data[p*64 +: 64] !== exp_rd[p]) begin
          errors++;
          bad++;
          if (bad == 1)
            $display("FAIL random_read cycle=%0d port=%0d addr=%0d got=%h required=%h",
                     i, p, a[p], rd_data[p*64 +: 64], exp_rd[p]);
        end
      end
      checks++;
      if (link_q !== exp_link) begin
        errors++;
        $display("FAIL random_link cycle=%0d got=%h required=%h", i, link_q, exp_link);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int held_bad;
    run_cycle(5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 64'h77, 1'b0);
    run_cycle(5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++;
    if (rd_data[63:0] !== 64'h77) begin
      errors++;
      $display("FAIL pre_reset_write got=%h required=%h", rd_data[63:0], 64'h77);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_addr = {5'd31, 5'd12, 5'd3};
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hDEAD; link_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    held_bad = 0;
    while (busy === 1'b1 && n < 100) begin
      if (rd_data !== 192'd0 || link_q !== 64'd0) held_bad++;
      wr_addr = ($urandom_range(0, 1) != 0) ? 5'd12 : 5'd3;
      wr_data = {$urandom, $urandom};
      link_en = $urandom_range(0, 1);
      tick();
      n++;
    end
    wr_en = 1'b0; link_en = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = i;
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL mid_reset_sweep_length busy cycles=%0d required=32", n);
    end
    checks++;
    if (held_bad !== 0) begin
      errors++;
      $display("FAIL busy_outputs_held nonzero cycles=%0d required=0", held_bad);
    end
    run_cycle(5'd3, 5'd12, 5'd31, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++;
    if (rd_data[63:0] !== 64'h3 || rd_data[127:64] !== 64'hC || rd_data[191:128] !== 64'h1F) begin
      errors++;
      $display("FAIL mid_reset_values got=%h required=%h", rd_data, {64'h1F, 64'hC, 64'h3});
    end
    checks++;
    if (link_q !== 64'h1F) begin
      errors++;
      $display("FAIL mid_reset_link got=%h required=%h", link_q, 64'h1F);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_link();
    test_zero_reg();
    test_same_cycle();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
